// File: rtl/mult_arb_32bit.sv
// rtl/mult_arb_32bit.sv - two-requester arbiter sharing one 32x32 unsigned multiplier
//
// multiplier_32bit : combinational unsigned multiplier
//   A, B : 32-bit unsigned operands
//   P    : 64-bit exact product
//
// mult_arb_32bit : arbitrates two operand requesters onto one multiplier
//   RR                     : 1 = round-robin on ties, 0 = req0 always wins ties
//   clk, rst_n             : clock, asynchronous active-low reset
//   reqN_valid/a/b/ready   : requester N operands and accept strobe (N = 0, 1)
//   rsp_valid/id/p/ready   : product handshake, id names the owning requester
//   busy                   : high whenever an operation is in flight

module multiplier_32bit (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] P
);
    assign P = {32'd0, A} * {32'd0, B};
endmodule

module mult_arb_32bit #(
    parameter int RR = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [63:0] rsp_p,
    input  logic        rsp_ready,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, RSP} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [63:0] mul_p;
    logic        last_grant;
    logic        grant;
    logic        accept;

    multiplier_32bit u_mult (
        .A (op_a),
        .B (op_b),
        .P (mul_p)
    );

    // Grant choice; only meaningful while accept is high.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = (RR != 0) ? ~last_grant : 1'b0;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                // Readies are gated by rst_n so nothing is offered while held in reset.
                if (rst_n && (req0_valid || req1_valid)) begin
                    accept     = 1'b1;
                    req0_ready = ~grant;
                    req1_ready = grant;
                    state_next = MUL;
                end
            end
            MUL: begin
                state_next = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            rsp_id     <= 1'b0;
            rsp_p      <= 64'd0;
            last_grant <= 1'b1;
        end else begin
            state <= state_next;
            if (accept) begin
                op_a       <= grant ? req1_a : req0_a;
                op_b       <= grant ? req1_b : req0_b;
                rsp_id     <= grant;
                last_grant <= grant;
            end
            // rsp_p only changes here, so it stays stable throughout RSP.
            if (state == MUL) begin
                rsp_p <= mul_p;
            end
        end
    end
endmodule

// File: tb/tb_mult_arb_32bit.sv
// tb/tb_mult_arb_32bit.sv - directed self-checking bench for mult_arb_32bit

module tb_mult_arb_32bit;
    logic        clk;
    logic        rst_n;

    logic        r_v0, r_v1, r_rdy0, r_rdy1, r_rsp_valid, r_rsp_id, r_rsp_ready, r_busy;
    logic [31:0] r_a0, r_b0, r_a1, r_b1;
    logic [63:0] r_rsp_p;

    logic        f_v0, f_v1, f_rdy0, f_rdy1, f_rsp_valid, f_rsp_id, f_rsp_ready, f_busy;
    logic [31:0] f_a0, f_b0, f_a1, f_b1;
    logic [63:0] f_rsp_p;

    int n_cmp;
    int n_err;

    mult_arb_32bit #(.RR(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r_v0), .req0_a(r_a0), .req0_b(r_b0), .req0_ready(r_rdy0),
        .req1_valid(r_v1), .req1_a(r_a1), .req1_b(r_b1), .req1_ready(r_rdy1),
        .rsp_valid(r_rsp_valid), .rsp_id(r_rsp_id), .rsp_p(r_rsp_p),
        .rsp_ready(r_rsp_ready), .busy(r_busy)
    );

    mult_arb_32bit #(.RR(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(f_v0), .req0_a(f_a0), .req0_b(f_b0), .req0_ready(f_rdy0),
        .req1_valid(f_v1), .req1_a(f_a1), .req1_b(f_b1), .req1_ready(f_rdy1),
        .rsp_valid(f_rsp_valid), .rsp_id(f_rsp_id), .rsp_p(f_rsp_p),
        .rsp_ready(f_rsp_ready), .busy(f_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        r_v0 = 1'b1; r_v1 = 1'b1; f_v0 = 1'b1; f_v1 = 1'b1;
        r_a0 = 32'd1; r_b0 = 32'd1; r_a1 = 32'd1; r_b1 = 32'd1;
        f_a0 = 32'd1; f_b0 = 32'd1; f_a1 = 32'd1; f_b1 = 32'd1;
        r_rsp_ready = 1'b1; f_rsp_ready = 1'b1;
        step(); step();
        n_cmp++; if ({r_rdy0, r_rdy1, f_rdy0, f_rdy1} !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", {r_rdy0, r_rdy1, f_rdy0, f_rdy1}); end
        n_cmp++; if ({r_rsp_valid, r_rsp_id, r_busy} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl got=%b exp=000", {r_rsp_valid, r_rsp_id, r_busy}); end
        n_cmp++; if (r_rsp_p !== 64'd0) begin n_err++; $display("FAIL reset_rsp_p got=%h exp=0", r_rsp_p); end
        n_cmp++; if ({f_rsp_valid, f_rsp_id, f_busy} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl_fp got=%b exp=000", {f_rsp_valid, f_rsp_id, f_busy}); end
        r_v0 = 1'b0; r_v1 = 1'b0; f_v0 = 1'b0; f_v1 = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_rr_alternate();
        int n_acc, n_rsp, last_c;
        logic g;
        n_acc = 0; n_rsp = 0; last_c = 0;
        r_a0 = 32'd10; r_b0 = 32'd11; r_a1 = 32'd20; r_b1 = 32'd21;
        r_v0 = 1'b1; r_v1 = 1'b1; r_rsp_ready = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            n_cmp++; if (r_rdy0 && r_rdy1) begin n_err++; $display("FAIL rr_both_ready cycle=%0d got=11 exp=one-hot", c); end
            if (r_rdy0 || r_rdy1) begin
                g = r_rdy1;
                n_cmp++; if (g !== n_acc[0]) begin n_err++; $display("FAIL rr_grant idx=%0d got=%b exp=%b", n_acc, g, n_acc[0]); end
                if (n_acc > 0) begin
                    n_cmp++; if (c - last_c !== 3) begin n_err++; $display("FAIL rr_interval got=%0d exp=3", c - last_c); end
                end
                last_c = c;
                n_acc++;
            end
            if (r_rsp_valid) begin
                n_cmp++; if (r_rsp_id !== n_rsp[0]) begin n_err++; $display("FAIL rr_rsp_id idx=%0d got=%b exp=%b", n_rsp, r_rsp_id, n_rsp[0]); end
                n_cmp++; if (r_rsp_p !== (n_rsp[0] ? 64'd420 : 64'd110)) begin n_err++; $display("FAIL rr_rsp_p idx=%0d got=%0d exp=%0d", n_rsp, r_rsp_p, n_rsp[0] ? 420 : 110); end
                n_rsp++;
            end
            step();
        end
        r_v0 = 1'b0; r_v1 = 1'b0;
        n_cmp++; if (n_acc !== 4) begin n_err++; $display("FAIL rr_accept_count got=%0d exp=4", n_acc); end
        n_cmp++; if (n_rsp !== 4) begin n_err++; $display("FAIL rr_rsp_count got=%0d exp=4", n_rsp); end
        step();
    endtask

    task automatic test_fixed_priority();
        int n_acc, n_rsp;
        n_acc = 0; n_rsp = 0;
        f_a0 = 32'd2; f_b0 = 32'd3; f_a1 = 32'd4; f_b1 = 32'd5;
        f_v0 = 1'b1; f_v1 = 1'b1; f_rsp_ready = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            n_cmp++; if (f_rdy1 !== 1'b0) begin n_err++; $display("FAIL fp_req1_ready cycle=%0d got=%b exp=0", c, f_rdy1); end
            if (f_rdy0) n_acc++;
            if (f_rsp_valid) begin
                n_cmp++; if ({f_rsp_id, f_rsp_p} !== {1'b0, 64'd6}) begin n_err++; $display("FAIL fp_rsp got id=%b p=%0d exp id=0 p=6", f_rsp_id, f_rsp_p); end
                n_rsp++;
            end
            step();
        end
        f_v0 = 1'b0; f_v1 = 1'b0;
        n_cmp++; if (n_acc !== 4) begin n_err++; $display("FAIL fp_accept_count got=%0d exp=4", n_acc); end
        n_cmp++; if (n_rsp !== 4) begin n_err++; $display("FAIL fp_rsp_count got=%0d exp=4", n_rsp); end
        step();
    endtask

    task automatic test_single_req0();
        r_a0 = 32'd3; r_b0 = 32'd5; r_v0 = 1'b1; r_rsp_ready = 1'b1;
        #1;
        n_cmp++; if ({r_rdy0, r_rdy1} !== 2'b10) begin n_err++; $display("FAIL s0_accept got=%b exp=10", {r_rdy0, r_rdy1}); end
        step();
        r_v0 = 1'b0;
        #1;
        n_cmp++; if ({r_rdy0, r_rsp_valid, r_busy} !== 3'b001) begin n_err++; $display("FAIL s0_mul got=%b exp=001", {r_rdy0, r_rsp_valid, r_busy}); end
        step();
        n_cmp++; if ({r_rsp_valid, r_rsp_id} !== 2'b10) begin n_err++; $display("FAIL s0_rsp_ctrl got=%b exp=10", {r_rsp_valid, r_rsp_id}); end
        n_cmp++; if (r_rsp_p !== 64'd15) begin n_err++; $display("FAIL s0_rsp_p got=%0d exp=15", r_rsp_p); end
        step();
        n_cmp++; if ({r_rsp_valid, r_busy} !== 2'b00) begin n_err++; $display("FAIL s0_done got=%b exp=00", {r_rsp_valid, r_busy}); end
    endtask

    task automatic test_single_req1_max();
        r_a1 = 32'hFFFF_FFFF; r_b1 = 32'hFFFF_FFFF; r_v1 = 1'b1; r_rsp_ready = 1'b1;
        #1;
        n_cmp++; if ({r_rdy0, r_rdy1} !== 2'b01) begin n_err++; $display("FAIL s1_accept got=%b exp=01", {r_rdy0, r_rdy1}); end
        step();
        // Scribble on the operands after acceptance; the product must not change.
        r_v1 = 1'b0; r_a1 = 32'd0; r_b1 = 32'd0;
        step();
        n_cmp++; if ({r_rsp_valid, r_rsp_id} !== 2'b11) begin n_err++; $display("FAIL s1_rsp_ctrl got=%b exp=11", {r_rsp_valid, r_rsp_id}); end
        n_cmp++; if (r_rsp_p !== 64'hFFFF_FFFE_0000_0001) begin n_err++; $display("FAIL s1_rsp_p got=%h exp=fffffffe00000001", r_rsp_p); end
        step();
    endtask

    task automatic test_backpressure();
        r_a0 = 32'd1234; r_b0 = 32'd1000; r_v0 = 1'b1; r_rsp_ready = 1'b0;
        #1;
        n_cmp++; if (r_rdy0 !== 1'b1) begin n_err++; $display("FAIL bp_accept got=%b exp=1", r_rdy0); end
        step();
        r_v1 = 1'b1;
        step();
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if ({r_rsp_valid, r_rsp_id, r_busy, r_rdy0, r_rdy1} !== 5'b10100) begin n_err++; $display("FAIL bp_hold cycle=%0d got=%b exp=10100", c, {r_rsp_valid, r_rsp_id, r_busy, r_rdy0, r_rdy1}); end
            n_cmp++; if (r_rsp_p !== 64'd1234000) begin n_err++; $display("FAIL bp_rsp_p cycle=%0d got=%0d exp=1234000", c, r_rsp_p); end
            if (c < 4) step();
        end
        r_rsp_ready = 1'b1; r_v0 = 1'b0; r_v1 = 1'b0;
        step();
        n_cmp++; if ({r_rsp_valid, r_busy} !== 2'b00) begin n_err++; $display("FAIL bp_release got=%b exp=00", {r_rsp_valid, r_busy}); end
    endtask

    task automatic test_reset_in_mul();
        logic seen;
        seen = 1'b0;
        r_a0 = 32'd7; r_b0 = 32'd9; r_v0 = 1'b1; r_rsp_ready = 1'b1;
        #1;
        n_cmp++; if (r_rdy0 !== 1'b1) begin n_err++; $display("FAIL rm_accept got=%b exp=1", r_rdy0); end
        step();
        r_v0 = 1'b0;
        #1;
        n_cmp++; if (r_busy !== 1'b1) begin n_err++; $display("FAIL rm_busy got=%b exp=1", r_busy); end
        rst_n = 1'b0; r_v1 = 1'b1;
        #1;
        n_cmp++; if ({r_rsp_valid, r_rsp_id, r_busy, r_rdy0, r_rdy1} !== 5'b00000) begin n_err++; $display("FAIL rm_reset_ctrl got=%b exp=00000", {r_rsp_valid, r_rsp_id, r_busy, r_rdy0, r_rdy1}); end
        n_cmp++; if (r_rsp_p !== 64'd0) begin n_err++; $display("FAIL rm_reset_p got=%0d exp=0", r_rsp_p); end
        step();
        r_v1 = 1'b0; rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (r_rsp_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rm_stale_rsp got=%b exp=0", seen); end
        r_a0 = 32'd6; r_b0 = 32'd7; r_v0 = 1'b1;
        #1;
        n_cmp++; if (r_rdy0 !== 1'b1) begin n_err++; $display("FAIL rm_next_accept got=%b exp=1", r_rdy0); end
        step();
        r_v0 = 1'b0;
        step();
        n_cmp++; if ({r_rsp_valid, r_rsp_id, r_rsp_p} !== {2'b10, 64'd42}) begin n_err++; $display("FAIL rm_next_rsp got v=%b id=%b p=%0d exp v=1 id=0 p=42", r_rsp_valid, r_rsp_id, r_rsp_p); end
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_rr_alternate();
        test_fixed_priority();
        test_single_req0();
        test_single_req1_max();
        test_backpressure();
        test_reset_in_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
